// File: rtl/mmio_stream_port_pkg.sv
// cpu24_mmio_pkg: bus widths, register offsets and STATUS/CTRL bit positions
// shared by the mmio_stream_port window decoder and its FIFO.
package cpu24_mmio_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 14;

  // Word offset inside the 4-word window (mem_addr[1:0]).
  typedef enum logic [1:0] {
    OFF_DATA  = 2'd0,
    OFF_LAST  = 2'd1,
    OFF_STAT  = 2'd2,
    OFF_TOTAL = 2'd3
  } off_e;

  // STATUS read fields.
  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_CNT_LSB = 8;
  localparam int unsigned ST_CNT_W   = 8;

  // CTRL write fields.
  localparam int unsigned CTRL_CLR_OVF = 0;
  localparam int unsigned CTRL_FLUSH   = 1;

endpackage

// File: rtl/mmio_stream_port_if.sv
// mmio_stream_port_if: CPU external-memory bus plus the outgoing 24-bit
// valid/ready stream. 'slave' is the responder side, 'master' the CPU/consumer.
interface mmio_stream_port_if;
  import cpu24_mmio_pkg::*;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              hit_q;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport slave (
    input  mem_we, mem_addr, mem_wdata, out_ready,
    output mem_rdata, hit_q, out_valid, out_data, out_last
  );

  modport master (
    output mem_we, mem_addr, mem_wdata, out_ready,
    input  mem_rdata, hit_q, out_valid, out_data, out_last
  );

endinterface

// File: rtl/mmio_stream_port_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO. dout shows the head with no
// added latency (zero when empty). push while full is accepted only if a pop
// happens in the same cycle. flush empties the FIFO and wins over push/pop.
// Ports: clk, rst (async, active-low), push, pop, flush, din, dout, count,
// full, empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 25,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[PTR_W:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // When full with a simultaneous pop, wr_ptr == rd_ptr: the head is consumed
  // at this edge, so overwriting its slot is safe.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_stream_port.sv
// mmio_stream_port: 4-word MMIO window on the cpu24 external bus. Stores to
// DATA/DATA_LAST feed a FWFT FIFO drained onto a valid/ready stream; STATUS
// and TOTAL are readable with one-cycle registered latency (hit_q marks it).
// Ports: clk, rst (async, active-low), bus (mmio_stream_port_if.slave).
module mmio_stream_port
  import cpu24_mmio_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h3FFC,
  parameter int unsigned       DEPTH     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_stream_port_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              hit;
  off_e              off;
  logic              wr;
  logic              rd;
  logic              pop;
  logic              push_req;
  logic              accept;
  logic              flush;
  logic              ovf;
  logic [DATA_W-1:0] total;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W:0]   fifo_dout;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  assign hit      = (bus.mem_addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
  assign off      = off_e'(bus.mem_addr[1:0]);
  assign wr       = hit && bus.mem_we;
  assign rd       = hit && !bus.mem_we;
  assign pop      = bus.out_valid && bus.out_ready;
  assign push_req = wr && (off == OFF_DATA || off == OFF_LAST);
  assign accept   = push_req && (!full || pop);
  assign flush    = wr && (off == OFF_STAT) && bus.mem_wdata[CTRL_FLUSH];

  sync_fifo_fwft #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .din   ({off == OFF_LAST, bus.mem_wdata}),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = !empty;
  assign bus.out_last  = fifo_dout[DATA_W];
  assign bus.out_data  = fifo_dout[DATA_W-1:0];

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STAT: begin
        rd_val[ST_EMPTY] = empty;
        rd_val[ST_FULL]  = full;
        rd_val[ST_OVF]   = ovf;
        rd_val[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(count);
      end
      OFF_TOTAL: rd_val = total;
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf           <= 1'b0;
      total         <= '0;
      bus.mem_rdata <= '0;
      bus.hit_q     <= 1'b0;
    end else begin
      bus.hit_q     <= rd;
      bus.mem_rdata <= rd ? rd_val : '0;

      if (wr && off == OFF_STAT && bus.mem_wdata[CTRL_CLR_OVF])
        ovf <= 1'b0;
      else if (push_req && !accept)
        ovf <= 1'b1;

      if (wr && off == OFF_TOTAL)
        total <= '0;
      else if (accept)
        total <= total + 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_stream_port.sv
module tb_mmio_stream_port;

  localparam logic [13:0] BASE  = 14'h3FFC;
  localparam int          DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mmio_stream_port_if bus ();

  mmio_stream_port #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: queue of {last, data}, sticky overflow, push total.
  logic [24:0] q[$];
  logic        m_ovf = 1'b0;
  logic [23:0] m_tot = '0;
  logic [24:0] seen[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] m_status();
    int unsigned n = q.size();
    return 24'((n << 8) | (int'(m_ovf) << 2) | (int'(n == DEPTH) << 1) | int'(n == 0));
  endfunction

  task automatic step(input logic we, input logic [13:0] addr, input logic [23:0] wd,
                      input logic rdy);
    logic        hit;
    int unsigned off;
    logic        pop;
    logic [23:0] exp_rd;
    int unsigned n_before;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = wd;
    bus.out_ready = rdy;
    hit      = ((addr >> 2) == (BASE >> 2));
    off      = addr % 4;
    n_before = q.size();
    pop      = (n_before != 0) && rdy;
    exp_rd   = '0;
    if (hit && !we) begin
      if (off == 2) exp_rd = m_status();
      else if (off == 3) exp_rd = m_tot;
    end
    if (bus.out_valid && rdy) seen.push_back({bus.out_last, bus.out_data});
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (hit && we) begin
      if (off < 2) begin
        if (n_before < DEPTH || pop) begin
          q.push_back({off == 1, wd});
          m_tot = m_tot + 24'd1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (off == 2) begin
        if (wd[0]) m_ovf = 1'b0;
        if (wd[1]) q.delete();
      end else begin
        m_tot = '0;
      end
    end
    chk("rdata", 32'(bus.mem_rdata), 32'(exp_rd));
    chk("hit_q", 32'(bus.hit_q), 32'(hit && !we));
    chk("valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("data",  32'(bus.out_data), q.size() != 0 ? 32'(q[0][23:0]) : 32'd0);
    chk("last",  32'(bus.out_last), q.size() != 0 ? 32'(q[0][24]) : 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_tot = '0;
  endtask

  initial begin
    logic [13:0] a;
    logic [23:0] d;
    bus.mem_we = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_hit",   32'(bus.hit_q), 32'd0);
    chk("rst_rdata", 32'(bus.mem_rdata), 32'd0);
    chk("rst_data",  32'(bus.out_data), 32'd0);
    chk("rst_last",  32'(bus.out_last), 32'd0);
    @(negedge clk) rst = 1'b1;

    step(1'b0, BASE + 14'd2, '0, 1'b0);
    chk("stat_reset", 32'(bus.mem_rdata), 32'h000001);
    chk("stat_reset_hit", 32'(bus.hit_q), 32'd1);
    step(1'b0, 14'h0000, '0, 1'b0);
    chk("hit_one_cycle", 32'(bus.hit_q), 32'd0);

    // Three pushes, then drain
    step(1'b1, BASE, 24'h111111, 1'b0);
    step(1'b1, BASE, 24'h222222, 1'b0);
    step(1'b1, BASE + 14'd1, 24'hABCDEF, 1'b0);
    step(1'b0, BASE + 14'd2, '0, 1'b0);
    chk("stat_3", 32'(bus.mem_rdata), 32'h000300);
    seen.delete();
    repeat (3) step(1'b0, 14'h0100, '0, 1'b1);
    chk("drain_n", 32'(seen.size()), 32'd3);
    if (seen.size() == 3) begin
      chk("drain0", 32'(seen[0]), 32'h0111111);
      chk("drain1", 32'(seen[1]), 32'h0222222);
      chk("drain2", 32'(seen[2]), 32'h1ABCDEF);
    end
    step(1'b0, BASE + 14'd3, '0, 1'b0);
    chk("total_3", 32'(bus.mem_rdata), 32'd3);

    // Overflow
    step(1'b1, BASE + 14'd3, 24'h123456, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, BASE, 24'(i + 16), 1'b0);
    step(1'b0, BASE + 14'd2, '0, 1'b0);
    chk("stat_ovf", 32'(bus.mem_rdata), 32'h000806);
    step(1'b0, BASE + 14'd3, '0, 1'b0);
    chk("total_8", 32'(bus.mem_rdata), 32'd8);
    step(1'b1, BASE + 14'd2, 24'h000001, 1'b0);
    step(1'b0, BASE + 14'd2, '0, 1'b0);
    chk("stat_clr", 32'(bus.mem_rdata), 32'h000802);

    // Push while full with simultaneous pop
    step(1'b1, BASE, 24'h5A5A5A, 1'b1);
    step(1'b0, BASE + 14'd2, '0, 1'b0);
    chk("stat_fullpop", 32'(bus.mem_rdata), 32'h000802);
    seen.delete();
    repeat (9) step(1'b0, 14'h0100, '0, 1'b1);
    chk("fullpop_n", 32'(seen.size()), 32'd8);
    if (seen.size() == 8) chk("fullpop_last", 32'(seen[7]), 32'h05A5A5A);

    // Flush with a pending pop
    for (int i = 0; i < 5; i++) step(1'b1, BASE, 24'($urandom), 1'b0);
    step(1'b1, BASE + 14'd2, 24'h000002, 1'b1);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, BASE + 14'd2, '0, 1'b0);
    chk("flush_stat", 32'(bus.mem_rdata), 32'h000001);

    // Async reset mid-drain
    for (int i = 0; i < 4; i++) step(1'b1, BASE, 24'($urandom), 1'b0);
    step(1'b0, BASE + 14'd2, '0, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_hit",   32'(bus.hit_q), 32'd0);
    chk("arst_rdata", 32'(bus.mem_rdata), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    model_reset();
    step(1'b0, BASE + 14'd2, '0, 1'b0);
    chk("arst_stat", 32'(bus.mem_rdata), 32'h000001);

    // Out-of-window accesses
    step(1'b1, BASE - 14'd1, 24'hFFFFFF, 1'b0);
    step(1'b1, BASE + 14'd4, 24'hFFFFFF, 1'b0);
    step(1'b0, BASE - 14'd1, '0, 1'b0);
    chk("miss_hit_lo", 32'(bus.hit_q), 32'd0);
    step(1'b0, BASE + 14'd4, '0, 1'b0);
    chk("miss_hit_hi", 32'(bus.hit_q), 32'd0);
    step(1'b0, BASE + 14'd2, '0, 1'b0);
    chk("miss_stat", 32'(bus.mem_rdata), 32'h000001);
    step(1'b0, BASE + 14'd3, '0, 1'b0);
    chk("miss_total", 32'(bus.mem_rdata), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) a = 14'($urandom);
      else a = BASE + 14'($urandom_range(0, 3));
      d = 24'($urandom);
      if (a == BASE + 14'd2 && $urandom_range(0, 15) != 0) d[1] = 1'b0;
      step(1'($urandom), a, d, $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_stream_port.md
# mmio_stream_port

Memory-mapped responder on the cpu24multi external memory bus (`mem_we_ext` / `mem_addr_ext` / `mem_data_in_ext` / `mem_data_out_ext`). It decodes a 4-word address window and accepts CPU stores into an internal FIFO. It drains that FIFO onto a 24-bit valid/ready stream toward host or debug logic, and answers CPU loads of status and counters. It sits beside RAM24 on the shared bus; the top level muxes read data using `hit_q`.

## Interface
- `BASE_ADDR`, 14'h3FFC, window base; bits [1:0] must be 0.
- `DEPTH`, 8, FIFO entries; power of two, 2..64.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_we`  in  1  CPU write strobe (the CPU's `mem_we_ext`).
- `mem_addr`  in  14  CPU word address.
- `mem_wdata`  in  24  CPU store data (the CPU's `mem_data_in_ext`).
- `mem_rdata`  out  24  registered load data for the window.
- `hit_q`  out  1  high for the cycle in which `mem_rdata` is valid for a window read.
- `out_valid`  out  1  stream word available.
- `out_data`  out  24  stream word (FIFO head).
- `out_last`  out  1  head word was pushed via DATA_LAST.
- `out_ready`  in  1  consumer accepts.

## Operation
- Hit: `mem_addr[13:2] == BASE_ADDR[13:2]`. Offset is `mem_addr[1:0]`. Every bus cycle is one access. No request/ack handshake.
- Offset 0, DATA:
  - Write pushes `{0, mem_wdata}`.
  - Read returns 0.
- Offset 1, DATA_LAST:
  - Write pushes `{1, mem_wdata}`.
  - Read returns 0.
- Offset 2, STATUS/CTRL, read fields:
  - [0] empty
  - [1] full
  - [2] overflow (sticky)
  - [15:8] count (zero-extended)
  - all other bits 0
- Offset 2, STATUS/CTRL, write fields:
  - bit0=1 clears overflow.
  - bit1=1 flushes the FIFO (count←0).
  - Other bits are ignored.
- Offset 3, TOTAL:
  - Read returns a 24-bit count of accepted pushes; it wraps 24'hFFFFFF→0.
  - Write with any data clears it to 0.
- Push acceptance: accepted if `!full`, or if a pop occurs in the same cycle. Otherwise the word is dropped, overflow←1, and TOTAL is unchanged.
- Pop: `out_valid && out_ready`. `out_valid = !empty`.
- When empty, `out_data` and `out_last` read 0.
- Flush in the same cycle as a pop: flush wins and the FIFO ends empty.
- Overflow-set and CTRL clear cannot collide, because there is a single bus.
- Non-hit accesses: no state change; `hit_q`←0, `mem_rdata`←0.

## Timing
- Reset (async assert): FIFO empty, overflow 0, TOTAL 0, `mem_rdata` 0, `hit_q` 0, `out_valid` 0, `out_data` 0, `out_last` 0.
- Reset release is synchronised by the top level and is not handled here.
- Read latency is 1 cycle, matching RAM24. For a read at edge N, `mem_rdata` and `hit_q` hold from edge N until edge N+1.
- Read values reflect state before edge N's updates.
- Write effects are visible at edge N:
  - A push at edge N makes `out_valid` high after N, when the FIFO was previously empty.
  - The STATUS read in cycle N+1 shows the updated count.
- FIFO is first-word-fall-through, with zero added latency from head to `out_data`.
- Sustained throughput is 1 push and 1 pop per cycle.
- `out_data` and `out_last` hold stable while `out_valid && !out_ready`.

## Structure
- Package `cpu24_mmio_pkg` holds:
  - `DATA_W=24`, `ADDR_W=14`
  - offset constants `OFF_DATA`, `OFF_LAST`, `OFF_STAT`, `OFF_TOTAL`
  - STATUS bit positions
  - CTRL bit positions
- Sub-module `sync_fifo_fwft` (`WIDTH=25`, `DEPTH`):
  - ports: push, pop, flush, din, dout, count, full, empty
  - pointer width `$clog2(DEPTH)`, count width `$clog2(DEPTH)+1`
- The top block holds decode, the overflow/TOTAL registers and the read-data register.

## Test plan
- Reset, then read STATUS at BASE+2. Require `mem_rdata` = 24'h000001 and `hit_q`=1 for one cycle, with `out_valid`=0.
- With `out_ready`=0:
  - Write 24'h111111, then 24'h222222 to BASE+0, then 24'hABCDEF to BASE+1.
  - Read STATUS: require 24'h000300.
  - Raise `out_ready`: require the stream 111111, 222222, ABCDEF on consecutive cycles, with `out_last` only on ABCDEF.
  - TOTAL must read 3.
- With `out_ready`=0, write 9 words.
  - STATUS must read 24'h000806 (count 8, full, overflow).
  - TOTAL must read 8.
  - Write CTRL 24'h000001: STATUS must read 24'h000802.
- Fill to full, hold `out_ready`=1, and write DATA 24'h5A5A5A in the same cycle as a pop.
  - Require no overflow, count still 8, and 5A5A5A delivered last.
- Write CTRL 24'h000002 with 5 entries queued while a pop is pending.
  - Require `out_valid`=0 next cycle and STATUS count 0.
- Assert `rst` low mid-drain with 4 entries queued.
  - Require `out_valid`, `hit_q` and `mem_rdata` to drop to 0 immediately.
  - After release, STATUS must read 24'h000001.
  - Accesses at BASE-1 and BASE+4 must leave `hit_q`=0 and state unchanged.
